compare_sequencer: RTL
======================

Name: compare_sequencer

Overview:
- Initiator-side controller for the power-gated multi-bit comparator.
- Accepts operand pairs on a valid/ready input handshake, registers them onto the comparator operand bus, and pulses the comparator reset.
- Waits for the comparator's solved indication, checks that the result flags are consistent, and returns an encoded result on a valid/ready output handshake.
- Sits between the datapath operand source and the comparator instance. It does not contain the comparator.

Parameters:
- N, 7: operand MSB index; operands are N+1 bits wide ([N:0]).
- SETTLE, 1: WAIT cycles, 1..15, that are ignored before cmp_solved is first sampled.
- TIMEOUT, 15: maximum WAIT cycles, SETTLE+1..255, before the sequencer aborts with an error.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept a pair.
- in_a  in  N+1  operand A.
- in_b  in  N+1  operand B.
- cmp_a  out  N+1  registered operand A to the comparator.
- cmp_b  out  N+1  registered operand B to the comparator.
- cmp_reset  out  1  comparator reset.
- cmp_less  in  1  comparator less_than.
- cmp_equal  in  1  comparator equal_to.
- cmp_greater  in  1  comparator greater_than.
- cmp_solved  in  1  comparator solved.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  2  result code: 00 = A==B, 01 = A<B, 10 = A>B, 11 = invalid.
- out_error  out  1  set together with out_result==11.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: single clock `clock`. Reset `reset` is synchronous and active-high, sampled on posedge clock only.
- Reset values: state=IDLE, cmp_a=0, cmp_b=0, out_valid=0, out_result=00, out_error=0, busy=0, wait counter=0.
- in_ready = (state==IDLE) && !reset. It is combinational from state only.
- cmp_reset = reset || (state==CLEAR).
- States:
  - IDLE: on in_valid&&in_ready, register in_a into cmp_a and in_b into cmp_b, then go to CLEAR.
  - CLEAR: lasts exactly 1 cycle. cmp_reset=1, counter cleared to 0. Go to WAIT.
  - WAIT: counter increments every cycle.
    - cmp_solved is ignored while counter < SETTLE.
    - Once counter >= SETTLE, sample the flags on each cycle cmp_solved=1:
      - exactly one of less/equal/greater high: out_result = its code, out_error=0;
      - two or more high: out_result=11, out_error=1.
    - Either way, set out_valid=1 and go to HOLD.
    - If counter reaches TIMEOUT without an accepted solved: out_result=11, out_error=1, out_valid=1, go to HOLD.
    - Solved takes priority over timeout in the same cycle.
  - HOLD: out_valid=1. out_result and out_error are held stable until out_valid&&out_ready. On acceptance, out_valid=0 next cycle and go to IDLE.
- Operand stability: cmp_a and cmp_b change only on an IDLE capture. They stay stable through CLEAR, WAIT and HOLD.
- Latency: capture at edge T. Earliest out_valid is high after edge T+2+SETTLE, which is 3 cycles at the default SETTLE=1. Throughput is at most one pair per SETTLE+4 cycles.
- Backpressure:
  - in_valid outside IDLE is ignored; nothing is dropped, because in_ready=0.
  - out_ready while out_valid=0 has no effect.
- Reset mid-operation: from any state, the next edge goes to IDLE with all reset values applied. An in-flight result is discarded. cmp_reset is high for the whole reset assertion.
- Back-to-back: no IDLE bypass. After HOLD acceptance, at least one IDLE cycle precedes the next capture.

Optional Feature:
- Macro: COMPARE_SEQUENCER_STATS_EN.
- When defined, the block adds these ports:
  - stat_lt, stat_eq, stat_gt, stat_err: each an out, 16-bit saturating counter.
  - stat_clear: in, 1 bit, synchronous clear.
- A counter increments once per accepted result (out_valid&&out_ready) of the matching code.
- Counters saturate at 16'hFFFF and are cleared by reset or stat_clear. stat_clear has priority over an increment in the same cycle.
- When the macro is undefined, these ports and counters are absent and there is no other behavioural difference.

Test Plan:
- Reset, then a=8'h3C, b=8'h3C; comparator model answers equal after 1 cycle -> out_result=00, out_error=0, out_valid high 3 cycles after the capture edge.
- a=8'h10, b=8'hF0, with out_ready held low for 5 cycles -> out_result=01 stable for all 5 cycles; in_ready=0 throughout; IDLE follows acceptance.
- a=8'hA5, b=8'h5A; model asserts solved with greater and equal both high -> out_result=11, out_error=1.
- Model never asserts solved -> exactly TIMEOUT=15 WAIT cycles, then out_result=11, out_error=1.
- Reset asserted during WAIT -> next edge: state IDLE, out_valid=0, cmp_a=0, cmp_b=0, in_ready=1 after reset is released; the in-flight result never appears.
- With COMPARE_SEQUENCER_STATS_EN defined: 3 less, 2 greater, 1 error -> stat_lt=3, stat_gt=2, stat_err=1, stat_eq=0; after a stat_clear pulse all four read 0.

Source files
------------

// File: rtl/compare_sequencer.sv
// compare_sequencer: sequences operand pairs through the power-gated comparator; define COMPARE_SEQUENCER_STATS_EN to add per-code result counters
module compare_sequencer #(
   parameter int N = 7,
   parameter int SETTLE = 1,
   parameter int TIMEOUT = 15
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [N:0] in_a,
   input  logic [N:0] in_b,
   output logic [N:0] cmp_a,
   output logic [N:0] cmp_b,
   output logic       cmp_reset,
   input  logic       cmp_less,
   input  logic       cmp_equal,
   input  logic       cmp_greater,
   input  logic       cmp_solved,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] out_result,
   output logic       out_error,
`ifdef COMPARE_SEQUENCER_STATS_EN
   output logic [15:0] stat_lt,
   output logic [15:0] stat_eq,
   output logic [15:0] stat_gt,
   output logic [15:0] stat_err,
   input  logic        stat_clear,
`endif
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, CLEAR, WAIT, HOLD} state_t;
   state_t state;
   logic [7:0] cnt;
   logic [1:0] nf, code;
   assign in_ready = (state == IDLE) && !reset;
   assign cmp_reset = reset || (state == CLEAR);
   assign busy = (state != IDLE);
   assign nf = 2'(cmp_less) + 2'(cmp_equal) + 2'(cmp_greater);
   // anything other than exactly one flag is an inconsistent answer
   assign code = nf != 2'd1 ? 2'b11 : cmp_less ? 2'b01 : cmp_greater ? 2'b10 : 2'b00;
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         cmp_a <= '0;
         cmp_b <= '0;
         out_valid <= 1'b0;
         out_result <= 2'b00;
         out_error <= 1'b0;
         cnt <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               cmp_a <= in_a;
               cmp_b <= in_b;
               state <= CLEAR;
            end
            CLEAR: begin
               cnt <= '0;
               state <= WAIT;
            end
            WAIT: begin
               cnt <= cnt + 8'd1;
               if (cnt >= 8'(SETTLE) && cmp_solved) begin
                  out_result <= code;
                  out_error <= (code == 2'b11);
                  out_valid <= 1'b1;
                  state <= HOLD;
               end else if (cnt == 8'(TIMEOUT - 1)) begin
                  out_result <= 2'b11;
                  out_error <= 1'b1;
                  out_valid <= 1'b1;
                  state <= HOLD;
               end
            end
            HOLD: if (out_ready) begin
               out_valid <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
`ifdef COMPARE_SEQUENCER_STATS_EN
   logic acc;
   assign acc = out_valid && out_ready;
   always_ff @(posedge clock) begin
      if (reset || stat_clear) begin
         stat_lt <= '0;
         stat_eq <= '0;
         stat_gt <= '0;
         stat_err <= '0;
      end else if (acc) begin
         if (out_result == 2'b01 && stat_lt != 16'hFFFF) stat_lt <= stat_lt + 16'd1;
         if (out_result == 2'b00 && stat_eq != 16'hFFFF) stat_eq <= stat_eq + 16'd1;
         if (out_result == 2'b10 && stat_gt != 16'hFFFF) stat_gt <= stat_gt + 16'd1;
         if (out_result == 2'b11 && stat_err != 16'hFFFF) stat_err <= stat_err + 16'd1;
      end
   end
`endif
endmodule
